div_request_sequencer: RTL

// - Front end for the shared unsigned iterative divider in the execute stage. It takes RISC-V M-extension
//   DIV/DIVU/REM/REMU requests from issue, converts signed operands to magnitudes and drives the divider.
// - It applies sign correction, resolves divide-by-zero and overflow without launching the divider, and

---
 rtl/div_request_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/div_request_sequencer.sv
// rtl/div_request_sequencer.sv - DIV/DIVU/REM/REMU front end for a shared unsigned iterative divider
// Optional DIV_REM_FUSE_EN: reuse the last divider result when the next request has the same operands.
module div_request_sequencer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_start,
  output logic [XLEN-1:0]  div_numerator,
  output logic [XLEN-1:0]  div_denominator,
  input  logic             div_ready_o,
  input  logic             div_valid,
  output logic             div_ready_i,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [XLEN-1:0]  result_data,
  output logic [TAG_W-1:0] result_tag
);

  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [TAG_W-1:0] tag_q;
  logic             rem_sel_q;
  logic             signed_q;
  logic             quo_neg_q;
  logic             dvd_neg_q;
  logic [XLEN-1:0]  num_q;
  logic [XLEN-1:0]  den_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  result_q;

  logic             acc_signed;
  logic             acc_rem;
  logic             rs1_neg;
  logic             rs2_neg;
  logic [XLEN-1:0]  rs1_mag;
  logic [XLEN-1:0]  rs2_mag;
  logic             is_div0;
  logic             is_ovf;
  logic             is_special;
  logic [XLEN-1:0]  special_data;
  logic             accept;
  logic             fuse_hit;
  logic [XLEN-1:0]  fuse_data;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;

  // Illegal funct3[2]=0 decodes as DIVU: unsigned, quotient selected.
  always_comb begin
    acc_signed   = req_funct3[2] & ~req_funct3[0];
    acc_rem      = req_funct3[2] & req_funct3[1];
    rs1_neg      = acc_signed & req_rs1[XLEN-1];
    rs2_neg      = acc_signed & req_rs2[XLEN-1];
    rs1_mag      = rs1_neg ? (ZERO - req_rs1) : req_rs1;
    rs2_mag      = rs2_neg ? (ZERO - req_rs2) : req_rs2;
    is_div0      = (req_rs2 == ZERO);
    is_ovf       = acc_signed && (req_rs1 == MIN_INT) && (req_rs2 == ALL_ONE);
    is_special   = is_div0 | is_ovf;
    special_data = ZERO;
    if (is_div0) begin
      special_data = acc_rem ? req_rs1 : ALL_ONE;
    end else if (is_ovf) begin
      special_data = acc_rem ? ZERO : req_rs1;
    end
  end

  assign accept  = (state == IDLE) && req_valid;
  assign quo_fix = quo_neg_q ? (ZERO - quo_q) : quo_q;
  assign rem_fix = dvd_neg_q ? (ZERO - rem_q) : rem_q;

`ifdef DIV_REM_FUSE_EN
  logic            fuse_valid;
  logic            fuse_signed;
  logic [XLEN-1:0] fuse_rs1;
  logic [XLEN-1:0] fuse_rs2;
  logic [XLEN-1:0] fuse_quo;
  logic [XLEN-1:0] fuse_rem;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;

  assign fuse_hit  = fuse_valid && (fuse_rs1 == req_rs1) && (fuse_rs2 == req_rs2) &&
                     (fuse_signed == acc_signed);
  assign fuse_data = acc_rem ? fuse_rem : fuse_quo;

  // Only divider-computed results are stored; special cases never touch the pair.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fuse_valid  <= 1'b0;
      fuse_signed <= 1'b0;
      fuse_rs1    <= ZERO;
      fuse_rs2    <= ZERO;
      fuse_quo    <= ZERO;
      fuse_rem    <= ZERO;
      rs1_q       <= ZERO;
      rs2_q       <= ZERO;
    end else begin
      if (accept && !is_special && !fuse_hit) begin
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
      end
      if (state == FIXUP) begin
        fuse_valid  <= 1'b1;
        fuse_signed <= signed_q;
        fuse_rs1    <= rs1_q;
        fuse_rs2    <= rs2_q;
        fuse_quo    <= quo_fix;
        fuse_rem    <= rem_fix;
      end
    end
  end
`else
  assign fuse_hit  = 1'b0;
  assign fuse_data = ZERO;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    div_start    = 1'b0;
    div_ready_i  = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = (is_special || fuse_hit) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (div_ready_o) begin
          div_start  = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        div_ready_i = 1'b1;
        if (div_valid) begin
          next_state = FIXUP;
        end
      end
      FIXUP: begin
        next_state = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_q     <= '0;
      rem_sel_q <= 1'b0;
      signed_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      dvd_neg_q <= 1'b0;
      num_q     <= ZERO;
      den_q     <= ZERO;
      quo_q     <= ZERO;
      rem_q     <= ZERO;
      result_q  <= ZERO;
    end else begin
      if (accept) begin
        tag_q     <= req_tag;
        rem_sel_q <= acc_rem;
        signed_q  <= acc_signed;
        quo_neg_q <= rs1_neg ^ rs2_neg;
        dvd_neg_q <= rs1_neg;
        if (is_special) begin
          result_q <= special_data;
        end else if (fuse_hit) begin
          result_q <= fuse_data;
        end else begin
          num_q <= rs1_mag;
          den_q <= rs2_mag;
        end
      end
      if ((state == WAIT) && div_valid) begin
        quo_q <= div_quotient;
        rem_q <= div_remainder;
      end
      if (state == FIXUP) begin
        result_q <= rem_sel_q ? rem_fix : quo_fix;
      end
    end
  end

  assign div_numerator   = num_q;
  assign div_denominator = den_q;
  assign result_data     = result_q;
  assign result_tag      = tag_q;

endmodule
